// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Holds the op codes, the FSM state codes and the divide-by-zero quotient constant.
package mdu_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CALC = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Sliced down to the datapath width by users; wide enough for any sensible DATA_W.
  localparam logic [63:0] DIV_ZERO_LO = '1;

endpackage

// File: rtl/mdu_sign_fix.sv
// Sign handling for signed MULT/DIV: magnitude extraction at capture time and
// conditional negation of product, quotient and remainder at completion.
module mdu_sign_fix
  import mdu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] src_a_i,
  input  logic [DATA_W-1:0] src_b_i,
  output logic [DATA_W-1:0] mag_a_o,
  output logic [DATA_W-1:0] mag_b_o,
  output logic              neg_main_o,
  output logic              neg_rem_o,
  input  logic              fix_is_div_i,
  input  logic              fix_neg_main_i,
  input  logic              fix_neg_rem_i,
  input  logic [DATA_W-1:0] raw_hi_i,
  input  logic [DATA_W-1:0] raw_lo_i,
  output logic [DATA_W-1:0] fix_hi_o,
  output logic [DATA_W-1:0] fix_lo_o
);

  logic              is_signed;
  logic              a_neg;
  logic              b_neg;
  logic [2*DATA_W-1:0] prod_raw;
  logic [2*DATA_W-1:0] prod_fix;

  assign is_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
  assign a_neg     = is_signed & src_a_i[DATA_W-1];
  assign b_neg     = is_signed & src_b_i[DATA_W-1];

  assign mag_a_o    = a_neg ? ('0 - src_a_i) : src_a_i;
  assign mag_b_o    = b_neg ? ('0 - src_b_i) : src_b_i;
  assign neg_main_o = a_neg ^ b_neg;
  // Remainder follows the dividend's sign.
  assign neg_rem_o  = a_neg;

  assign prod_raw = {raw_hi_i, raw_lo_i};
  assign prod_fix = fix_neg_main_i ? ('0 - prod_raw) : prod_raw;

  always_comb begin
    fix_hi_o = prod_fix[2*DATA_W-1:DATA_W];
    fix_lo_o = prod_fix[DATA_W-1:0];
    if (fix_is_div_i) begin
      fix_lo_o = fix_neg_main_i ? ('0 - raw_lo_i) : raw_lo_i;
      fix_hi_o = fix_neg_rem_i ? ('0 - raw_hi_i) : raw_hi_i;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO registers, MTHI/MTLO writes
// and a combinational HI/LO read port. One shift-add or restoring step per cycle.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] src_a_i,
  input  logic [DATA_W-1:0] src_b_i,
  input  logic              hi_we_i,
  input  logic              lo_we_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              hilo_sel_i,
  output logic [DATA_W-1:0] hilo_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              div_zero_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] acc_hi_q, acc_hi_d;
  logic [DATA_W-1:0] acc_lo_q, acc_lo_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic [DATA_W-1:0] a_raw_q, a_raw_d;
  logic              neg_main_q, neg_main_d;
  logic              neg_rem_q, neg_rem_d;
  logic              dz_q, dz_d;

  logic [DATA_W-1:0] mag_a, mag_b;
  logic              neg_main, neg_rem;
  logic              start_is_div;
  logic              cur_is_div;
  logic [DATA_W-1:0] fix_hi, fix_lo;

  logic [DATA_W:0]   mul_sum, mul_add;
  logic [DATA_W:0]   div_shift, div_diff;
  logic [DATA_W-1:0] step_hi, step_lo;

  mdu_sign_fix #(
    .DATA_W(DATA_W)
  ) u_sign_fix (
    .op_i          (op_i),
    .src_a_i       (src_a_i),
    .src_b_i       (src_b_i),
    .mag_a_o       (mag_a),
    .mag_b_o       (mag_b),
    .neg_main_o    (neg_main),
    .neg_rem_o     (neg_rem),
    .fix_is_div_i  (cur_is_div),
    .fix_neg_main_i(neg_main_q),
    .fix_neg_rem_i (neg_rem_q),
    .raw_hi_i      (step_hi),
    .raw_lo_i      (step_lo),
    .fix_hi_o      (fix_hi),
    .fix_lo_o      (fix_lo)
  );

  assign start_is_div = (op_i == OP_DIVU) || (op_i == OP_DIV);
  assign cur_is_div   = (op_q == OP_DIVU) || (op_q == OP_DIV);

  // Shift-add: acc_lo holds the multiplier, product grows into acc_hi from the top.
  assign mul_sum = {1'b0, acc_hi_q} + {1'b0, operand_q};
  assign mul_add = acc_lo_q[0] ? mul_sum : {1'b0, acc_hi_q};

  // Restoring divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
  assign div_shift = {acc_hi_q, acc_lo_q[DATA_W-1]};
  assign div_diff  = div_shift - {1'b0, operand_q};

  always_comb begin
    step_hi = acc_hi_q;
    step_lo = acc_lo_q;
    unique case (op_q)
      OP_MULTU, OP_MULT: begin
        step_hi = mul_add[DATA_W:1];
        step_lo = {mul_add[0], acc_lo_q[DATA_W-1:1]};
      end
      OP_DIVU, OP_DIV: begin
        if (!div_diff[DATA_W]) begin
          step_hi = div_diff[DATA_W-1:0];
          step_lo = {acc_lo_q[DATA_W-2:0], 1'b1};
        end else begin
          step_hi = div_shift[DATA_W-1:0];
          step_lo = {acc_lo_q[DATA_W-2:0], 1'b0};
        end
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    operand_d  = operand_q;
    a_raw_d    = a_raw_q;
    neg_main_d = neg_main_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    case (state_q)
      ST_CALC: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          if (dz_q) begin
            hi_d = a_raw_q;
            lo_d = DIV_ZERO_LO[DATA_W-1:0];
          end else begin
            hi_d = fix_hi;
            lo_d = fix_lo;
          end
        end
      end
      default: begin
        // IDLE and DONE behave identically, which gives back-to-back issue from DONE.
        state_d = ST_IDLE;
        if (hi_we_i) hi_d = wdata_i;
        if (lo_we_i) lo_d = wdata_i;
        if (start_i) begin
          state_d    = ST_CALC;
          cnt_d      = CNT_W'(DATA_W - 1);
          op_d       = op_i;
          acc_hi_d   = '0;
          acc_lo_d   = start_is_div ? mag_a : mag_b;
          operand_d  = start_is_div ? mag_b : mag_a;
          a_raw_d    = src_a_i;
          neg_main_d = neg_main;
          neg_rem_d  = neg_rem & start_is_div;
          dz_d       = start_is_div && (src_b_i == '0);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= OP_MULTU;
      hi_q       <= '0;
      lo_q       <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      operand_q  <= '0;
      a_raw_q    <= '0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      operand_q  <= operand_d;
      a_raw_q    <= a_raw_d;
      neg_main_q <= neg_main_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
    end
  end

  assign hilo_o     = hilo_sel_i ? hi_q : lo_q;
  assign busy_o     = (state_q == ST_CALC);
  assign done_o     = (state_q == ST_DONE);
  assign div_zero_o = (state_q == ST_DONE) && dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: a reference model pushes expected HI/LO
// at issue, and results are popped and compared when done_o pulses.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         hi_we, lo_we, sel;
  logic [W-1:0] hilo;
  logic         busy, done, dz;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t         sb_q[$];
  int           n_checks = 0;
  int           n_pass = 0;
  logic [W-1:0] last_lo;

  mult_div_unit #(.DATA_W(W)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .op_i      (op),
    .src_a_i   (a),
    .src_b_i   (b),
    .hi_we_i   (hi_we),
    .lo_we_i   (lo_we),
    .wdata_i   (wdata),
    .hilo_sel_i(sel),
    .hilo_o    (hilo),
    .busy_o    (busy),
    .done_o    (done),
    .div_zero_o(dz)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic read_hilo(input logic s, output logic [W-1:0] v);
    sel = s;
    #1;
    v = hilo;
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t        e;
    logic [63:0] p;
    longint      sx, sy;
    int          iq, ir;
    e.dz = 1'b0;
    e.hi = '0;
    e.lo = '0;
    if (o == OP_MULTU) begin
      p = {32'b0, x} * {32'b0, y};
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (o == OP_MULT) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      p = 64'(sx * sy);
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (y == '0) begin
      e.lo = 32'hFFFF_FFFF;
      e.hi = x;
      e.dz = 1'b1;
    end else if (o == OP_DIVU) begin
      e.lo = x / y;
      e.hi = x % y;
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      e.lo = 32'h8000_0000;
      e.hi = '0;
    end else begin
      iq = int'($signed(x)) / int'($signed(y));
      ir = int'($signed(x)) % int'($signed(y));
      e.lo = iq;
      e.hi = ir;
    end
    return e;
  endfunction

  // Issues at posedge+1 in an IDLE or DONE cycle; returns in the done_o cycle.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit disturb);
    exp_t         e;
    int           cycles;
    logic [W-1:0] v;
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    sb_q.push_back(model(o, x, y));
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 2'($urandom);
    check_eq("busy_after_start", {31'b0, busy}, 1);
    read_hilo(1'b0, v);
    check_eq("lo_prev_in_calc", v, last_lo);
    cycles = 0;
    while (!done && cycles < 100) begin
      if (disturb && cycles == 4) begin
        start = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h0000_1234;
      end else begin
        start = 1'b0;
        lo_we = 1'b0;
      end
      @(posedge clk);
      #1;
      cycles++;
      if (disturb && cycles == 6) begin
        read_hilo(1'b0, v);
        check_eq("mtlo_ignored_busy", v, last_lo);
        check_eq("still_busy", {31'b0, busy}, 1);
      end
    end
    start = 1'b0;
    lo_we = 1'b0;
    check_eq("latency", cycles, W);
    e = sb_q.pop_front();
    read_hilo(1'b1, v);
    check_eq("hi", v, e.hi);
    read_hilo(1'b0, v);
    check_eq("lo", v, e.lo);
    check_eq("div_zero", {31'b0, dz}, {31'b0, e.dz});
    check_eq("idle_at_done", {31'b0, busy}, 0);
    last_lo = e.lo;
  endtask

  initial begin
    logic [W-1:0] v;
    int           dones;
    rst = 1'b1;
    start = 1'b0;
    op = OP_MULTU;
    a = '0;
    b = '0;
    wdata = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    sel = 1'b0;
    last_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    read_hilo(1'b0, v);
    check_eq("rst_lo", v, 0);
    read_hilo(1'b1, v);
    check_eq("rst_hi", v, 0);
    check_eq("rst_busy", {31'b0, busy}, 0);
    check_eq("rst_done", {31'b0, done}, 0);
    check_eq("rst_dz", {31'b0, dz}, 0);

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b1);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(OP_DIVU, 32'd100, 32'd0, 1'b0);
    run_op(OP_DIV, 32'hFFFF_FFCE, 32'd0, 1'b0);
    run_op(OP_DIVU, 32'hFFFF_FFF0, 32'd7, 1'b0);
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0);
    for (int i = 0; i < 8; i++) begin
      run_op(2'(i), $urandom, (i == 7) ? 32'($urandom_range(1, 9)) : $urandom, 1'b0);
    end
    @(posedge clk);
    #1;
    check_eq("done_one_cycle", {31'b0, done}, 0);

    hi_we = 1'b1;
    wdata = 32'hCAFE_0001;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    read_hilo(1'b1, v);
    check_eq("mthi_idle", v, 32'hCAFE_0001);
    lo_we = 1'b1;
    wdata = 32'hBEEF_0002;
    @(posedge clk);
    #1;
    lo_we = 1'b0;
    read_hilo(1'b0, v);
    check_eq("mtlo_idle", v, 32'hBEEF_0002);
    last_lo = 32'hBEEF_0002;

    // MTLO on the same edge as start: write lands first, result overwrites.
    lo_we = 1'b1;
    wdata = 32'h5555_AAAA;
    last_lo = 32'h5555_AAAA;
    run_op(OP_MULTU, 32'd12, 32'd34, 1'b0);

    // Reset in the middle of an operation.
    op = OP_DIVU;
    a = 32'd1000;
    b = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("midrst_busy", {31'b0, busy}, 0);
    check_eq("midrst_done", {31'b0, done}, 0);
    read_hilo(1'b1, v);
    check_eq("midrst_hi", v, 0);
    read_hilo(1'b0, v);
    check_eq("midrst_lo", v, 0);
    dones = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) dones++;
    end
    check_eq("no_done_after_rst", dones, 0);
    last_lo = '0;
    run_op(OP_DIV, 32'hFFFF_FF00, 32'd9, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
